// File: rtl/sync_pkg.sv
// sync_pkg: edge-mode encodings and filter counter sizing shared by the input conditioner
package sync_pkg;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;
  function automatic int cnt_width(input int filt_len);
    return (filt_len > 2) ? $clog2(filt_len) : 1;
  endfunction
endpackage

// File: rtl/sync_pulse_multi_if.sv
// sync_pulse_multi_if: per-channel inputs and conditioned outputs of the multi-channel conditioner
interface sync_pulse_multi_if #(parameter int CH = 4);
  logic [CH-1:0] sig_i;
  logic [CH-1:0] clr_i;
  logic [CH-1:0] level_o;
  logic [CH-1:0] pulse_o;
  logic [CH-1:0] evt_o;
  logic irq_o;
  modport master(output sig_i, clr_i, input level_o, pulse_o, evt_o, irq_o);
  modport slave(input sig_i, clr_i, output level_o, pulse_o, evt_o, irq_o);
endinterface

// File: rtl/sync_filter_ch.sv
// sync_filter_ch: one channel of synchroniser, glitch filter, edge pulse and sticky event flag
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN = 4,
  parameter logic [1:0] EDGE_MODE = EDGE_BOTH
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  input  logic clr_i,
  output logic level_o,
  output logic pulse_o,
  output logic evt_o
);
  localparam int CW = cnt_width(FILT_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, pulse_q, pulse_d, evt_q, evt_d;
  logic sync_s, diff, accept;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
    sync_s = sync_q[SYNC_STAGES-1];
    diff = sync_s != level_q;
    accept = diff && (cnt_q == CNT_MAX);
    cnt_d = (diff && !accept) ? cnt_q + 1'b1 : '0;
    level_d = accept ? sync_s : level_q;
    pulse_d = accept && (sync_s ? EDGE_MODE[0] : EDGE_MODE[1]);
    // A pulse arriving together with a clear keeps the flag set
    evt_d = pulse_q || (evt_q && !clr_i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      evt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      evt_q <= evt_d;
    end
  end
  assign level_o = level_q;
  assign pulse_o = pulse_q;
  assign evt_o = evt_q;
endmodule

// File: rtl/sync_pulse_multi.sv
// sync_pulse_multi: CH independent async-input conditioners with an OR-ed event interrupt
module sync_pulse_multi
  import sync_pkg::*;
#(
  parameter int CH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN = 4,
  parameter logic [1:0] EDGE_MODE = EDGE_BOTH
) (
  input logic clk,
  input logic rst,
  sync_pulse_multi_if.slave bus
);
  if (CH < 1 || SYNC_STAGES < 2 || FILT_LEN < 1 || EDGE_MODE == 2'b00) begin : g_bad_param
    $fatal(1, "sync_pulse_multi: illegal parameter set");
  end
  logic [CH-1:0] level, pulse, evt;
  for (genvar i = 0; i < CH; i++) begin : g_ch
    sync_filter_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN(FILT_LEN),
      .EDGE_MODE(EDGE_MODE)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .sig_i(bus.sig_i[i]),
      .clr_i(bus.clr_i[i]),
      .level_o(level[i]),
      .pulse_o(pulse[i]),
      .evt_o(evt[i])
    );
  end
  assign bus.level_o = level;
  assign bus.pulse_o = pulse;
  assign bus.evt_o = evt;
  assign bus.irq_o = |evt;
endmodule

// File: tb/tb_sync_pulse_multi.sv
// tb_sync_pulse_multi: scenario tasks with a queue of expected accept events for sync_pulse_multi
module tb_sync_pulse_multi;
  typedef struct {
    int cyc;
    logic [3:0] pulse;
    logic [3:0] level;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int cyc = 0;
  int checks = 0;
  int passed = 0;
  logic [3:0] exp_lvl = '0;
  logic [3:0] exp_evt = '0;
  exp_t sb[$];
  sync_pulse_multi_if #(.CH(4)) bus ();
  sync_pulse_multi_if #(.CH(4)) bus_r ();
  sync_pulse_multi #(.CH(4), .SYNC_STAGES(2), .FILT_LEN(4), .EDGE_MODE(2'b11)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  sync_pulse_multi #(.CH(4), .SYNC_STAGES(2), .FILT_LEN(4), .EDGE_MODE(2'b01)) dut_r (
    .clk(clk), .rst(rst), .bus(bus_r)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic test_reset;
    rst = 1'b1;
    bus.sig_i = '0; bus.clr_i = '0; bus_r.sig_i = '0; bus_r.clr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.level_o, bus.pulse_o, bus.evt_o, bus.irq_o} !== 13'd0)
      $display("FAIL reset_hold level=%b pulse=%b evt=%b irq=%b want 0", bus.level_o, bus.pulse_o, bus.evt_o, bus.irq_o);
    else passed++;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.level_o, bus.pulse_o, bus.evt_o, bus.irq_o} !== 13'd0)
        $display("FAIL reset_idle cyc=%0d level=%b pulse=%b evt=%b irq=%b want 0", cyc, bus.level_o, bus.pulse_o, bus.evt_o, bus.irq_o);
      else passed++;
    end
  endtask

  task automatic test_rise;
    exp_t e;
    @(negedge clk); bus.sig_i[0] = 1'b1;
    sb.push_back('{cyc + 6, 4'b0001, 4'b0001});
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if (sb.size() > 0 && cyc == sb[0].cyc) begin
        e = sb.pop_front();
        if (bus.pulse_o !== e.pulse || bus.level_o !== e.level || bus.evt_o !== exp_evt || bus.irq_o !== |exp_evt)
          $display("FAIL rise_accept cyc=%0d pulse=%b/%b level=%b/%b evt=%b/%b", cyc, bus.pulse_o, e.pulse, bus.level_o, e.level, bus.evt_o, exp_evt);
        else passed++;
        exp_lvl = e.level; exp_evt = exp_evt | e.pulse;
      end else if (bus.pulse_o !== 4'b0 || bus.level_o !== exp_lvl || bus.evt_o !== exp_evt || bus.irq_o !== |exp_evt)
        $display("FAIL rise_steady cyc=%0d pulse=%b/0000 level=%b/%b evt=%b/%b irq=%b", cyc, bus.pulse_o, bus.level_o, exp_lvl, bus.evt_o, exp_evt, bus.irq_o);
      else passed++;
    end
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL rise_timeout pending=%0d want 0", sb.size());
      sb.delete();
    end else passed++;
  endtask

  task automatic test_glitch;
    exp_t e;
    int c;
    @(negedge clk); bus.sig_i[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k == 2) bus.sig_i[1] = 1'b0;
      checks++;
      if (bus.pulse_o !== 4'b0 || bus.level_o !== exp_lvl || bus.evt_o !== exp_evt)
        $display("FAIL glitch3 cyc=%0d pulse=%b/0000 level=%b/%b evt=%b/%b", cyc, bus.pulse_o, bus.level_o, exp_lvl, bus.evt_o, exp_evt);
      else passed++;
    end
    @(negedge clk); bus.sig_i[1] = 1'b1; c = cyc;
    sb.push_back('{c + 6, 4'b0010, 4'b0011});
    sb.push_back('{c + 10, 4'b0010, 4'b0001});
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (k == 3) bus.sig_i[1] = 1'b0;
      checks++;
      if (sb.size() > 0 && cyc == sb[0].cyc) begin
        e = sb.pop_front();
        if (bus.pulse_o !== e.pulse || bus.level_o !== e.level || bus.evt_o !== exp_evt)
          $display("FAIL glitch4_accept cyc=%0d pulse=%b/%b level=%b/%b evt=%b/%b", cyc, bus.pulse_o, e.pulse, bus.level_o, e.level, bus.evt_o, exp_evt);
        else passed++;
        exp_lvl = e.level; exp_evt = exp_evt | e.pulse;
      end else if (bus.pulse_o !== 4'b0 || bus.level_o !== exp_lvl || bus.evt_o !== exp_evt)
        $display("FAIL glitch4_steady cyc=%0d pulse=%b/0000 level=%b/%b evt=%b/%b", cyc, bus.pulse_o, bus.level_o, exp_lvl, bus.evt_o, exp_evt);
      else passed++;
    end
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL glitch4_timeout pending=%0d want 0", sb.size());
      sb.delete();
    end else passed++;
  endtask

  task automatic test_clear;
    exp_t e;
    int c;
    @(negedge clk); bus.clr_i = 4'b0001;
    @(posedge clk); #1; bus.clr_i = '0;
    checks++;
    if (bus.evt_o !== 4'b0010 || bus.irq_o !== 1'b1)
      $display("FAIL clr_ch0 evt=%b/0010 irq=%b/1", bus.evt_o, bus.irq_o);
    else passed++;
    bus.clr_i = 4'b0010;
    @(posedge clk); #1; bus.clr_i = '0;
    checks++;
    if (bus.evt_o !== 4'b0000 || bus.irq_o !== 1'b0)
      $display("FAIL clr_all evt=%b/0000 irq=%b/0", bus.evt_o, bus.irq_o);
    else passed++;
    exp_evt = '0;
    @(negedge clk); bus.sig_i[2] = 1'b1; c = cyc;
    sb.push_back('{c + 6, 4'b0100, 4'b0101});
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if (sb.size() > 0 && cyc == sb[0].cyc) begin
        e = sb.pop_front();
        if (bus.pulse_o !== e.pulse || bus.level_o !== e.level || bus.evt_o !== exp_evt)
          $display("FAIL clr_set_accept cyc=%0d pulse=%b/%b level=%b/%b evt=%b/%b", cyc, bus.pulse_o, e.pulse, bus.level_o, e.level, bus.evt_o, exp_evt);
        else passed++;
        exp_lvl = e.level; exp_evt = exp_evt | e.pulse;
      end else if (bus.pulse_o !== 4'b0 || bus.level_o !== exp_lvl || bus.evt_o !== exp_evt)
        $display("FAIL clr_set_steady cyc=%0d pulse=%b/0000 level=%b/%b evt=%b/%b", cyc, bus.pulse_o, bus.level_o, exp_lvl, bus.evt_o, exp_evt);
      else passed++;
      bus.clr_i[2] = (cyc == c + 6);
    end
    checks++;
    if (sb.size() != 0 || bus.evt_o[2] !== 1'b1 || bus.irq_o !== 1'b1) begin
      $display("FAIL clr_set_wins pending=%0d evt2=%b/1 irq=%b/1", sb.size(), bus.evt_o[2], bus.irq_o);
      sb.delete();
    end else passed++;
  endtask

  task automatic test_rise_only;
    int c;
    @(negedge clk); bus_r.sig_i[3] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (bus_r.level_o[3] !== 1'b1 || bus_r.evt_o[3] !== 1'b1)
      $display("FAIL rmode_rise level3=%b/1 evt3=%b/1", bus_r.level_o[3], bus_r.evt_o[3]);
    else passed++;
    bus_r.clr_i[3] = 1'b1;
    @(posedge clk); #1; bus_r.clr_i[3] = 1'b0;
    @(negedge clk); bus_r.sig_i[3] = 1'b0; c = cyc;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus_r.pulse_o[3] !== 1'b0 || bus_r.evt_o[3] !== 1'b0 || bus_r.level_o[3] !== (cyc < c + 6))
        $display("FAIL rmode_fall cyc=%0d pulse3=%b/0 evt3=%b/0 level3=%b/%b", cyc, bus_r.pulse_o[3], bus_r.evt_o[3], bus_r.level_o[3], cyc < c + 6);
      else passed++;
    end
  endtask

  task automatic test_mid_reset;
    exp_t e;
    @(negedge clk); rst = 1'b1; bus.sig_i = 4'b0010; bus.clr_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    exp_lvl = 4'b0010; exp_evt = 4'b0010;
    checks++;
    if (bus.level_o !== exp_lvl || bus.evt_o !== exp_evt)
      $display("FAIL mid_rst_pre level=%b/%b evt=%b/%b", bus.level_o, exp_lvl, bus.evt_o, exp_evt);
    else passed++;
    @(negedge clk); bus.sig_i[0] = 1'b1;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({bus.level_o, bus.pulse_o, bus.evt_o, bus.irq_o} !== 13'd0)
      $display("FAIL mid_rst_async level=%b pulse=%b evt=%b irq=%b want 0", bus.level_o, bus.pulse_o, bus.evt_o, bus.irq_o);
    else passed++;
    @(negedge clk); bus.sig_i = 4'b0001;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    exp_lvl = '0; exp_evt = '0;
    sb.push_back('{cyc + 6, 4'b0001, 4'b0001});
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if (sb.size() > 0 && cyc == sb[0].cyc) begin
        e = sb.pop_front();
        if (bus.pulse_o !== e.pulse || bus.level_o !== e.level || bus.evt_o !== exp_evt)
          $display("FAIL mid_rst_accept cyc=%0d pulse=%b/%b level=%b/%b evt=%b/%b", cyc, bus.pulse_o, e.pulse, bus.level_o, e.level, bus.evt_o, exp_evt);
        else passed++;
        exp_lvl = e.level; exp_evt = exp_evt | e.pulse;
      end else if (bus.pulse_o !== 4'b0 || bus.level_o !== exp_lvl || bus.evt_o !== exp_evt)
        $display("FAIL mid_rst_steady cyc=%0d pulse=%b/0000 level=%b/%b evt=%b/%b", cyc, bus.pulse_o, bus.level_o, exp_lvl, bus.evt_o, exp_evt);
      else passed++;
    end
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL mid_rst_timeout pending=%0d want 0", sb.size());
      sb.delete();
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_clear();
    test_rise_only();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
